instruction_fetch: RTL

- Fetch stage directly upstream of the main control decoder.
- Owns the program counter and issues addresses to a synchronous instruction memory with 1-cycle read latency.
- Presents one 32-bit instruction per cycle, plus its PC and PC+4, to decode.
- Takes back the decoder's Jump/Branch/Bne outputs and the ALU zero flag, resolves control flow, and redirects the PC.

---
 rtl/instruction_fetch.sv | 101 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives a 1-cycle-latency instruction memory, presents instr/PC/PC+4 to decode.
// Result appears 1 cycle after request; stall with a valid instruction holds it in a skid register, no new request.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Bne,
  input  logic        alu_zero,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        redirect
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        out_valid_q, out_valid_d;
  logic        hold_valid_q, hold_valid_d;

  logic        stalled;
  logic        accept;
  logic        taken;
  logic [31:0] pc_seq;
  logic [31:0] br_offset;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] redirect_target;

  // A bubble has nothing to hold, so stall only bites when the presented slot is valid.
  assign stalled   = stall && out_valid_q;
  assign accept    = out_valid_q && !stall;
  assign imem_req  = !rst && !stalled;
  assign imem_addr = fetch_pc_q;

  assign instruction = !out_valid_q ? 32'h0 : (hold_valid_q ? hold_instr_q : imem_rdata);
  assign instr_valid = out_valid_q;
  assign pc_out      = out_pc_q;
  assign pc_plus4    = out_pc_q + 32'd4;

  assign taken    = Jump | (Branch & (alu_zero ^ Bne));
  assign redirect = accept && taken;

  assign pc_seq          = fetch_pc_q + STEP;
  assign br_offset       = {{14{instruction[15]}}, instruction[15:0], 2'b00};
  assign jump_target     = {pc_plus4[31:28], instruction[25:0], 2'b00};
  assign branch_target   = pc_plus4 + br_offset;
  assign redirect_target = Jump ? jump_target : branch_target;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    out_pc_d     = out_pc_q;
    out_valid_d  = out_valid_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;

    if (redirect) begin
      // The sequential fetch issued this cycle is squashed: one bubble.
      fetch_pc_d   = redirect_target;
      out_valid_d  = 1'b0;
      hold_valid_d = 1'b0;
    end else if (imem_req) begin
      fetch_pc_d   = pc_seq;
      out_pc_d     = fetch_pc_q;
      out_valid_d  = 1'b1;
      hold_valid_d = 1'b0;
    end else if (!hold_valid_q) begin
      // First stalled cycle: memory data is only valid now, capture it.
      hold_instr_d = imem_rdata;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      out_pc_q     <= 32'h0;
      out_valid_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= 32'h0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      out_pc_q     <= out_pc_d;
      out_valid_q  <= out_valid_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
    end
  end

endmodule
